nbr_pattern_gen: RTL and testbench

NBR_PATTERN_GEN -- requirements
Module: nbr_pattern_gen

---
 rtl/nbr_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_nbr_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nbr_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : nbr_pattern_gen
// Description : Two-stage pipelined test-pattern source producing the 2x2
//               neighbourhood {b11,b12,b21,b22} around a rotated source
//               coordinate. Each neighbour is rendered as a solid colour,
//               a checkerboard, a coordinate code or a frame-scrolling ramp,
//               or forced to zero with its out-of-bounds flag set.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk              clock, rising edge
//   i_reset_n          asynchronous active-low reset
//   i_hsyn             pixel-request strobe, one request per high cycle
//   i_fsyn             start-of-frame pulse (latches iv_mode, bumps frame count)
//   iv_p1x, iv_p2y     signed rotated source coordinates (COORD_W)
//   iv_width, iv_depth unsigned image size (COORD_W)
//   iv_mode            pattern select: 0 solid, 1 checker, 2 coord, 3 ramp
//   iv_color           base colour (PIX_W), sampled in stage 2
//   o_hsyn, o_fsyn     request / frame strobes delayed 2 cycles
//   ov_b11..ov_b22     neighbour pixels (PIX_W)
//   ov_oob             out-of-bounds flags {b22,b21,b12,b11}
// ============================================================================
module nbr_pattern_gen #(
  parameter int PIX_W    = 16,
  parameter int COORD_W  = 12,
  parameter int CHK_LOG2 = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_hsyn,
  input  logic               i_fsyn,
  input  logic [COORD_W-1:0] iv_p1x,
  input  logic [COORD_W-1:0] iv_p2y,
  input  logic [COORD_W-1:0] iv_width,
  input  logic [COORD_W-1:0] iv_depth,
  input  logic [1:0]         iv_mode,
  input  logic [PIX_W-1:0]   iv_color,
  output logic               o_hsyn,
  output logic               o_fsyn,
  output logic [PIX_W-1:0]   ov_b11,
  output logic [PIX_W-1:0]   ov_b12,
  output logic [PIX_W-1:0]   ov_b21,
  output logic [PIX_W-1:0]   ov_b22,
  output logic [3:0]         ov_oob
);

  // Two guard bits: one for the signed/unsigned mix, one for the +/-1 step.
  localparam int XW = COORD_W + 2;
  localparam logic signed [XW-1:0] ONE_S = XW'(1);

  // --------------------------------------------------------------------------
  // Neighbour coordinate arithmetic (combinational, feeds stage 1)
  // --------------------------------------------------------------------------
  logic signed [XW-1:0] p1x_s, p2y_s, half_w, half_d, w_max, d_max;
  logic signed [XW-1:0] x1, x2, y1, y2;
  logic                 x1_in, x2_in, y1_in, y2_in;
  logic [3:0]           inb;

  assign p1x_s  = {{2{iv_p1x[COORD_W-1]}}, iv_p1x};
  assign p2y_s  = {{2{iv_p2y[COORD_W-1]}}, iv_p2y};
  assign half_w = {3'b000, iv_width[COORD_W-1:1]};
  assign half_d = {3'b000, iv_depth[COORD_W-1:1]};
  // A zero-sized image gives a max of -1, so nothing is ever in bounds.
  assign w_max  = $signed({2'b00, iv_width}) - ONE_S;
  assign d_max  = $signed({2'b00, iv_depth}) - ONE_S;

  assign x1 = p1x_s + half_w;
  assign x2 = x1 + ONE_S;
  assign y2 = half_d - p2y_s;
  assign y1 = y2 - ONE_S;

  assign x1_in = !x1[XW-1] && (x1 <= w_max);
  assign x2_in = !x2[XW-1] && (x2 <= w_max);
  assign y1_in = !y1[XW-1] && (y1 <= d_max);
  assign y2_in = !y2[XW-1] && (y2 <= d_max);

  // Bit order matches ov_oob: {b22,b21,b12,b11}
  assign inb = {x2_in & y2_in, x1_in & y2_in, x2_in & y1_in, x1_in & y1_in};

  // --------------------------------------------------------------------------
  // Stage 1: capture request. Only the low byte of each coordinate is needed
  // downstream (mode codes, ramp and checker bit all live in bits [7:0]).
  // --------------------------------------------------------------------------
  logic       valid1;
  logic [7:0] x1_r, x2_r, y1_r, y2_r;
  logic [3:0] inb_r;
  logic       hsyn_d1, fsyn_d1;
  logic [1:0] mode_r;
  logic [7:0] frame_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid1    <= 1'b0;
      x1_r      <= '0;
      x2_r      <= '0;
      y1_r      <= '0;
      y2_r      <= '0;
      inb_r     <= '0;
      hsyn_d1   <= 1'b0;
      fsyn_d1   <= 1'b0;
      o_hsyn    <= 1'b0;
      o_fsyn    <= 1'b0;
      mode_r    <= 2'd0;
      frame_cnt <= 8'd0;
    end else begin
      valid1  <= i_hsyn;
      hsyn_d1 <= i_hsyn;
      fsyn_d1 <= i_fsyn;
      o_hsyn  <= hsyn_d1;
      o_fsyn  <= fsyn_d1;
      if (i_hsyn) begin
        x1_r  <= x1[7:0];
        x2_r  <= x2[7:0];
        y1_r  <= y1[7:0];
        y2_r  <= y2[7:0];
        inb_r <= inb;
      end
      // Mode and frame count update on the same edge that captures a
      // coincident request, so that request renders with the new frame state.
      if (i_fsyn) begin
        mode_r    <= iv_mode;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pattern rendering per neighbour (index = ov_oob bit position)
  // --------------------------------------------------------------------------
  logic [PIX_W-1:0] pix_w [4];

  for (genvar k = 0; k < 4; k++) begin : g_nbr
    localparam bit USE_X2 = (k % 2) == 1;
    localparam bit USE_Y2 = (k / 2) == 1;
    logic [7:0]       xs, ys;
    logic [PIX_W-1:0] pix;

    assign xs = USE_X2 ? x2_r : x1_r;
    assign ys = USE_Y2 ? y2_r : y1_r;

    always_comb begin
      pix = '0;
      case (mode_r)
        2'd0: pix = iv_color;
        2'd1: pix = (xs[CHK_LOG2] ^ ys[CHK_LOG2]) ? ~iv_color : iv_color;
        2'd2: pix[15:0] = {xs, ys};
        default: pix[7:0] = xs + frame_cnt;
      endcase
    end

    assign pix_w[k] = pix;
  end

  // --------------------------------------------------------------------------
  // Stage 2: register pixels and flags
  // --------------------------------------------------------------------------
  logic [PIX_W-1:0] pix_r [4];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < 4; k++) pix_r[k] <= '0;
      ov_oob <= 4'b1111;
    end else if (valid1) begin
      for (int k = 0; k < 4; k++) pix_r[k] <= inb_r[k] ? pix_w[k] : '0;
      ov_oob <= ~inb_r;
    end
  end

  assign ov_b11 = pix_r[0];
  assign ov_b12 = pix_r[1];
  assign ov_b21 = pix_r[2];
  assign ov_b22 = pix_r[3];

endmodule
`default_nettype wire

// File: tb/tb_nbr_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbr_pattern_gen
// Description : Directed self-checking bench for nbr_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbr_pattern_gen;

  logic        clk;
  logic        reset_n;
  logic        hsyn, fsyn;
  logic [11:0] p1x, p2y, width, depth;
  logic [1:0]  mode;
  logic [15:0] color;
  logic        out_hsyn, out_fsyn;
  logic [15:0] b11, b12, b21, b22;
  logic [3:0]  oob;

  int total = 0;
  int bad   = 0;

  nbr_pattern_gen #(.PIX_W(16), .COORD_W(12), .CHK_LOG2(3)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_hsyn(hsyn), .i_fsyn(fsyn),
    .iv_p1x(p1x), .iv_p2y(p2y), .iv_width(width), .iv_depth(depth),
    .iv_mode(mode), .iv_color(color),
    .o_hsyn(out_hsyn), .o_fsyn(out_fsyn),
    .ov_b11(b11), .ov_b12(b12), .ov_b21(b21), .ov_b22(b22), .ov_oob(oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request for one cycle; returns on the negedge after it drops.
  task automatic send_req(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    hsyn = 1'b1; p1x = x; p2y = y;
    @(negedge clk);
    hsyn = 1'b0;
  endtask

  task automatic fsyn_pulse(input logic [1:0] m);
    @(negedge clk);
    fsyn = 1'b1; mode = m;
    @(negedge clk);
    fsyn = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_hsyn !== 1'b0) begin bad++; $display("FAIL reset_hsyn: got %b expected 0", out_hsyn); end
    total++; if (out_fsyn !== 1'b0) begin bad++; $display("FAIL reset_fsyn: got %b expected 0", out_fsyn); end
    total++; if (oob !== 4'b1111) begin bad++; $display("FAIL reset_oob: got %b expected 1111", oob); end
    total++; if ({b11, b12, b21, b22} !== 64'h0) begin bad++; $display("FAIL reset_pix: got %h expected 0", {b11, b12, b21, b22}); end
    reset_n = 1'b1;
  endtask

  task automatic test_mode0;
    @(negedge clk);
    hsyn = 1'b1; p1x = 12'd0; p2y = 12'd0;
    @(negedge clk);
    hsyn = 1'b0;
    total++; if (out_hsyn !== 1'b0) begin bad++; $display("FAIL mode0_hsyn_early: got %b expected 0", out_hsyn); end
    @(negedge clk);
    total++; if (out_hsyn !== 1'b1) begin bad++; $display("FAIL mode0_hsyn: got %b expected 1", out_hsyn); end
    total++; if (b11 !== 16'hF800) begin bad++; $display("FAIL mode0_b11: got %h expected f800", b11); end
    total++; if (b12 !== 16'hF800) begin bad++; $display("FAIL mode0_b12: got %h expected f800", b12); end
    total++; if (b21 !== 16'hF800) begin bad++; $display("FAIL mode0_b21: got %h expected f800", b21); end
    total++; if (b22 !== 16'hF800) begin bad++; $display("FAIL mode0_b22: got %h expected f800", b22); end
    total++; if (oob !== 4'b0000) begin bad++; $display("FAIL mode0_oob: got %b expected 0000", oob); end
    @(negedge clk);
    total++; if (out_hsyn !== 1'b0) begin bad++; $display("FAIL mode0_hsyn_drop: got %b expected 0", out_hsyn); end
  endtask

  task automatic test_left_edge;
    send_req(12'hFF7, 12'd0);   // p1x = -9 -> x1 = -1, x2 = 0
    @(negedge clk);
    total++; if (b11 !== 16'h0000) begin bad++; $display("FAIL left_b11: got %h expected 0000", b11); end
    total++; if (b21 !== 16'h0000) begin bad++; $display("FAIL left_b21: got %h expected 0000", b21); end
    total++; if (b12 !== 16'hF800) begin bad++; $display("FAIL left_b12: got %h expected f800", b12); end
    total++; if (b22 !== 16'hF800) begin bad++; $display("FAIL left_b22: got %h expected f800", b22); end
    total++; if (oob !== 4'b0101) begin bad++; $display("FAIL left_oob: got %b expected 0101", oob); end
  endtask

  task automatic test_right_edge;
    send_req(12'd7, 12'd0);     // x1 = 15 (last column), x2 = 16
    @(negedge clk);
    total++; if (b11 !== 16'hF800) begin bad++; $display("FAIL right_b11: got %h expected f800", b11); end
    total++; if (b12 !== 16'h0000) begin bad++; $display("FAIL right_b12: got %h expected 0000", b12); end
    total++; if (b22 !== 16'h0000) begin bad++; $display("FAIL right_b22: got %h expected 0000", b22); end
    total++; if (oob !== 4'b1010) begin bad++; $display("FAIL right_oob: got %b expected 1010", oob); end
  endtask

  task automatic test_mode2;
    @(negedge clk);
    fsyn = 1'b1; mode = 2'd2;
    @(negedge clk);
    fsyn = 1'b0;
    total++; if (out_fsyn !== 1'b0) begin bad++; $display("FAIL fsyn_early: got %b expected 0", out_fsyn); end
    @(negedge clk);
    total++; if (out_fsyn !== 1'b1) begin bad++; $display("FAIL fsyn_delay: got %b expected 1", out_fsyn); end
    send_req(12'd2, 12'hFFF);   // x1 = 10, y2 = 9, y1 = 8
    @(negedge clk);
    total++; if (b11 !== 16'h0A08) begin bad++; $display("FAIL mode2_b11: got %h expected 0a08", b11); end
    total++; if (b12 !== 16'h0B08) begin bad++; $display("FAIL mode2_b12: got %h expected 0b08", b12); end
    total++; if (b21 !== 16'h0A09) begin bad++; $display("FAIL mode2_b21: got %h expected 0a09", b21); end
    total++; if (b22 !== 16'h0B09) begin bad++; $display("FAIL mode2_b22: got %h expected 0b09", b22); end
  endtask

  // Mode 2 still active: requests x1 = 8,9,10 with y1 = 7, y2 = 8.
  task automatic test_back_to_back;
    logic [15:0] exp11 [3];
    logic [15:0] exp22 [3];
    exp11[0] = 16'h0807; exp11[1] = 16'h0907; exp11[2] = 16'h0A07;
    exp22[0] = 16'h0908; exp22[1] = 16'h0A08; exp22[2] = 16'h0B08;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total++; if (out_hsyn !== 1'b1) begin bad++; $display("FAIL b2b_hsyn[%0d]: got %b expected 1", i - 2, out_hsyn); end
        total++; if (b11 !== exp11[i-2]) begin bad++; $display("FAIL b2b_b11[%0d]: got %h expected %h", i - 2, b11, exp11[i-2]); end
        total++; if (b22 !== exp22[i-2]) begin bad++; $display("FAIL b2b_b22[%0d]: got %h expected %h", i - 2, b22, exp22[i-2]); end
      end
      if (i < 3) begin
        hsyn = 1'b1; p1x = 12'(i); p2y = 12'd0;
      end else begin
        hsyn = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (out_hsyn !== 1'b0) begin bad++; $display("FAIL b2b_hsyn_end: got %b expected 0", out_hsyn); end
  endtask

  task automatic test_mode_latch;
    fsyn_pulse(2'd0);
    mode = 2'd1;                // changed mid-frame, must be ignored
    send_req(12'd0, 12'd0);
    @(negedge clk);
    total++; if (b11 !== 16'hF800) begin bad++; $display("FAIL latch_hold_b11: got %h expected f800", b11); end
    total++; if (b12 !== 16'hF800) begin bad++; $display("FAIL latch_hold_b12: got %h expected f800", b12); end
    // Coincident frame start and request: x1=8,x2=9,y1=7,y2=8, bit 3 checker.
    @(negedge clk);
    fsyn = 1'b1; hsyn = 1'b1; p1x = 12'd0; p2y = 12'd0;
    @(negedge clk);
    fsyn = 1'b0; hsyn = 1'b0;
    @(negedge clk);
    total++; if (b11 !== 16'h07FF) begin bad++; $display("FAIL latch_chk_b11: got %h expected 07ff", b11); end
    total++; if (b12 !== 16'h07FF) begin bad++; $display("FAIL latch_chk_b12: got %h expected 07ff", b12); end
    total++; if (b21 !== 16'hF800) begin bad++; $display("FAIL latch_chk_b21: got %h expected f800", b21); end
    total++; if (b22 !== 16'hF800) begin bad++; $display("FAIL latch_chk_b22: got %h expected f800", b22); end
  endtask

  task automatic test_mode3_wrap;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    fsyn_pulse(2'd3);           // frame_cnt = 1
    send_req(12'hFFD, 12'd0);   // x1 = 5, x2 = 6
    @(negedge clk);
    total++; if (b11 !== 16'h0006) begin bad++; $display("FAIL ramp1_b11: got %h expected 0006", b11); end
    total++; if (b12 !== 16'h0007) begin bad++; $display("FAIL ramp1_b12: got %h expected 0007", b12); end
    for (int i = 0; i < 255; i++) fsyn_pulse(2'd3);   // frame_cnt wraps to 0
    send_req(12'hFFD, 12'd0);
    @(negedge clk);
    total++; if (b11 !== 16'h0005) begin bad++; $display("FAIL ramp_wrap_b11: got %h expected 0005", b11); end
    total++; if (b12 !== 16'h0006) begin bad++; $display("FAIL ramp_wrap_b12: got %h expected 0006", b12); end
  endtask

  task automatic test_reset_midstream;
    int seen;
    @(negedge clk);
    hsyn = 1'b1; p1x = 12'd0; p2y = 12'd0;
    @(negedge clk);             // second request, first now in stage 1
    @(posedge clk); #1;
    total++; if (out_hsyn !== 1'b1) begin bad++; $display("FAIL mid_pre_hsyn: got %b expected 1", out_hsyn); end
    hsyn = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    total++; if (out_hsyn !== 1'b0) begin bad++; $display("FAIL mid_clr_hsyn: got %b expected 0", out_hsyn); end
    total++; if (b11 !== 16'h0000) begin bad++; $display("FAIL mid_clr_b11: got %h expected 0000", b11); end
    total++; if (oob !== 4'b1111) begin bad++; $display("FAIL mid_clr_oob: got %b expected 1111", oob); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_hsyn !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_ghost_hsyn: got %0d pulses expected 0", seen); end
    // First request after release: mode back to solid, 2-cycle latency.
    @(negedge clk);
    hsyn = 1'b1; p1x = 12'd0; p2y = 12'd0;
    @(negedge clk);
    hsyn = 1'b0;
    total++; if (out_hsyn !== 1'b0) begin bad++; $display("FAIL post_hsyn_early: got %b expected 0", out_hsyn); end
    @(negedge clk);
    total++; if (out_hsyn !== 1'b1) begin bad++; $display("FAIL post_hsyn: got %b expected 1", out_hsyn); end
    total++; if (b11 !== 16'hF800) begin bad++; $display("FAIL post_b11: got %h expected f800", b11); end
    total++; if (oob !== 4'b0000) begin bad++; $display("FAIL post_oob: got %b expected 0000", oob); end
  endtask

  initial begin
    reset_n = 1'b0;
    hsyn = 1'b0; fsyn = 1'b0;
    p1x = '0; p2y = '0;
    width = 12'd16; depth = 12'd16;
    mode = 2'd0; color = 16'hF800;
    test_reset();
    test_mode0();
    test_left_edge();
    test_right_edge();
    test_mode2();
    test_back_to_back();
    test_mode_latch();
    test_mode3_wrap();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
